// File: rtl/uart_pkg.sv
// Framing constants and FSM state type shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte hand-off between the UART receiver (master) and its consumer (slave).
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, single-byte holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      frame_err,
  output logic      overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic rx_s;
  logic rx_prev;

  uart_state_t          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 stop_ok;
  logic                 stop_bad;

  logic [DATA_BITS-1:0] dout;
  logic                 dv;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // rx_prev resets low so a start edge needs a high rx_s observed after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_prev <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_prev <= rx_s;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n    = '0;
          state_n  = IDLE;
          stop_ok  = rx_s;
          stop_bad = !rx_s;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A delivery coinciding with an accept replaces the consumed byte in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout      <= '0;
      dv        <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_ok && dv && !bus.data_ready;
      if (stop_ok && (!dv || bus.data_ready)) begin
        dout <= shreg;
        dv   <= 1'b1;
      end else if (dv && bus.data_ready) begin
        dv <= 1'b0;
      end
    end
  end

  assign bus.data_out   = dout;
  assign bus.data_valid = dv;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level event model plus directed literal checks.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB    = 16;
  localparam int          DV_LAT = 155;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic ready = 1'b0;
  logic frame_err;
  logic overrun;

  uart_rx_if bus_if ();
  assign bus_if.data_ready = ready;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .bus       (bus_if.master),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A frame that starts after edge E completes its stop sample so that outputs
  // change on edge E + DV_LAT (2 synchronizer cycles + half bit + 9 bits + 1).
  typedef struct {
    int         edge_no;
    logic [7:0] data;
    logic       stop;
  } ev_t;
  ev_t evq[$];

  logic       m_dv, m_fe, m_ov;
  logic [7:0] m_do;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dv <= 1'b0;
      m_do <= 8'h00;
      m_fe <= 1'b0;
      m_ov <= 1'b0;
      evq.delete();
    end else begin
      m_fe <= 1'b0;
      m_ov <= 1'b0;
      if (m_dv && ready) m_dv <= 1'b0;
      if (evq.size() > 0 && evq[0].edge_no == cyc + 1) begin
        if (!evq[0].stop) m_fe <= 1'b1;
        else if (!m_dv || ready) begin
          m_dv <= 1'b1;
          m_do <= evq[0].data;
        end else m_ov <= 1'b1;
        void'(evq.pop_front());
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  int   dv_cycles = 0;
  int   ov_cnt    = 0;
  int   fe_cnt    = 0;
  int   rise_cyc  = -1;
  int   fe_cyc    = -1;
  logic dv_prev   = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      chk("data_valid", {31'd0, bus_if.data_valid}, {31'd0, m_dv});
      chk("data_out",   {24'd0, bus_if.data_out},   {24'd0, m_do});
      chk("frame_err",  {31'd0, frame_err},         {31'd0, m_fe});
      chk("overrun",    {31'd0, overrun},           {31'd0, m_ov});
      if (bus_if.data_valid === 1'b1) begin
        dv_cycles++;
        if (!dv_prev) rise_cyc = cyc;
      end
      if (overrun === 1'b1) ov_cnt++;
      if (frame_err === 1'b1) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
      dv_prev = (bus_if.data_valid === 1'b1);
    end
  end

  // Called #1 after a rising edge; returns #1 after a rising edge, 160 cycles later.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    evq.push_back('{edge_no: cyc + DV_LAT, data: b, stop: stop});
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int e0, dvb, ovb, feb;

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("reset_dv",   {31'd0, bus_if.data_valid}, 32'd0);
    chk("reset_dout", {24'd0, bus_if.data_out},   32'h00);
    reset = 1'b0;
    idle(8);

    // 0xA5 frame: latency and value
    e0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("a5_rise_latency", rise_cyc - e0, 155);
    chk("a5_data", {24'd0, bus_if.data_out}, 32'hA5);
    chk("a5_valid_held", {31'd0, bus_if.data_valid}, 32'd1);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    idle(2);
    chk("a5_consumed", {31'd0, bus_if.data_valid}, 32'd0);

    // back-to-back with consumer stalled: second byte dropped
    ovb = ov_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(20);
    chk("ovr_count", ov_cnt - ovb, 1);
    chk("ovr_kept", {24'd0, bus_if.data_out}, 32'h3C);
    ready = 1'b1;
    idle(3);
    chk("ovr_drained", {31'd0, bus_if.data_valid}, 32'd0);
    chk("ovr_last", {24'd0, bus_if.data_out}, 32'h3C);

    // back-to-back with consumer always ready
    dvb = dv_cycles;
    ovb = ov_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(20);
    chk("rdy_dv_cycles", dv_cycles - dvb, 2);
    chk("rdy_no_ovr", ov_cnt - ovb, 0);
    chk("rdy_last", {24'd0, bus_if.data_out}, 32'hC3);

    // stop bit low
    dvb = dv_cycles;
    feb = fe_cnt;
    e0  = cyc;
    send_frame(8'h55, 1'b0);
    rx = 1'b1;
    idle(20);
    chk("ferr_count", fe_cnt - feb, 1);
    chk("ferr_latency", fe_cyc - e0, 155);
    chk("ferr_no_dv", dv_cycles - dvb, 0);
    chk("ferr_dout_kept", {24'd0, bus_if.data_out}, 32'hC3);

    // 4-cycle glitch, then a valid frame
    dvb = dv_cycles;
    rx  = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    chk("glitch_no_dv", dv_cycles - dvb, 0);
    send_frame(8'h81, 1'b1);
    idle(20);
    chk("glitch_next", {24'd0, bus_if.data_out}, 32'h81);
    chk("glitch_next_dv", dv_cycles - dvb, 1);

    // reset in the middle of a 0xFF frame, then a clean 0x12
    dvb = dv_cycles;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(62);
        reset = 1'b1;
        #1;
        chk("mid_reset_dv",   {31'd0, bus_if.data_valid}, 32'd0);
        chk("mid_reset_dout", {24'd0, bus_if.data_out},   32'h00);
        chk("mid_reset_ferr", {31'd0, frame_err},         32'd0);
        chk("mid_reset_ovr",  {31'd0, overrun},           32'd0);
        idle(3);
        reset = 1'b0;
      end
    join
    idle(20);
    chk("abandoned_frame", dv_cycles - dvb, 0);
    send_frame(8'h12, 1'b1);
    idle(20);
    chk("post_reset_data", {24'd0, bus_if.data_out}, 32'h12);
    chk("post_reset_dv", dv_cycles - dvb, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values are integers of 4 or more.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-005 SHALL have port data_out  output  8  received byte; stable while data_valid is high.
REQ-006 SHALL have port data_valid  output  1  data_out holds an unconsumed byte.
REQ-007 SHALL have port data_ready  input  1  consumer accepts data_out in any cycle where data_valid and data_ready are both high.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer before any use; rx_s is its output.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-012 IDLE -> START SHALL occur in the cycle (T0) where rx_s is low and its previous value was high; the counter clears at T0.
REQ-013 START SHALL sample rx_s at T0+H, where H = CLKS_PER_BIT/2 (integer division).
REQ-014 START exit at T0+H: sample low -> DATA; sample high -> IDLE, treated as a glitch, with no output.
REQ-015 DATA SHALL sample bit i (i=0..7) at T0+H+(i+1)*CLKS_PER_BIT and shift it into a shift register, LSB first.
REQ-016 After bit 7, DATA SHALL go to STOP, and STOP SHALL sample at T0+H+9*CLKS_PER_BIT.
REQ-017 STOP SHALL always return to IDLE after its sample.
REQ-018 STOP sample high: the byte is delivered to the holding register per REQ-020..022.
REQ-019 STOP sample low: frame_err SHALL be high for exactly the next cycle, the byte SHALL be discarded, and data_valid/data_out SHALL be unchanged.
REQ-020 On delivery with data_valid low, data_out SHALL load the byte and data_valid SHALL be high from the next cycle.
REQ-021 On delivery while data_valid is high and data_ready is low, the new byte SHALL be dropped, the old byte SHALL be kept, and overrun SHALL pulse for one cycle.
REQ-022 On delivery while data_valid and data_ready are both high, the old byte is consumed, the new byte loads, and data_valid stays high.
REQ-023 Accept without delivery: data_valid SHALL go low the next cycle, and data_out SHALL hold its last value.
REQ-024 data_valid SHALL NOT depend combinationally on data_ready.
REQ-025 A new start edge SHALL be detected in IDLE only after a high rx_s has been seen; back-to-back frames with a one-bit stop SHALL be received without loss.
REQ-026 The counter width SHALL be $clog2(CLKS_PER_BIT)+1, and the counter SHALL never wrap within a bit period.

Reset
REQ-027 While reset is high: state=IDLE; synchronizer flops=1; counter=0; shift register=0; data_out=8'h00; data_valid=0; frame_err=0; overrun=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no pulse.
REQ-029 After reset deasserts, the block SHALL require rx_s high and then a falling edge before receiving.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state typedef (IDLE/START/DATA/STOP), the data width constant 8, and the default CLKS_PER_BIT, so the existing transmitter uses the same framing constants.
REQ-031 The synchronizer SHALL be a sub-module named uart_sync2, with a parameterized reset value (1 here).
REQ-032 All other logic SHALL reside in uart_rx.

Verification (CLKS_PER_BIT=16, 10 ns clock)
REQ-033 Reset then frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> data_valid rises at T0+153, data_out=8'hA5, frame_err=0.
REQ-034 0x3C then 0xC3 back-to-back, data_ready held low, then raised after both -> data_out=8'h3C, one overrun pulse at the second delivery, and 0xC3 is never presented.
REQ-035 Same two frames with data_ready tied high -> data_out 8'h3C then 8'hC3, no overrun, data_valid high for one cycle per byte.
REQ-036 Frame 0x55 with the stop bit driven low -> one frame_err pulse at T0+153, and data_valid stays 0.
REQ-037 rx low for 4 cycles (glitch) -> FSM returns to IDLE at T0+8, no outputs; a following valid 0x81 frame is received correctly.
REQ-038 reset asserted at T0+60 of frame 0xFF, then a clean 0x12 frame -> no output from the first frame; 0x12 is delivered; all outputs match REQ-027 during reset.
